temp_report_scheduler: RTL and testbench

Round-robin scheduler that shares one byte-level UART transmitter between several PWM-temperature measurement channels. Each channel offers a 10-digit BCD low-period count through a valid/ready handshake. The block grants one channel at a time, latches its result, and streams a fixed 15-byte ASCII frame ("C<n>:<10 digits>\r\n") to the downstream UART byte serializer. It sits between the per-channel low-period counters and the shared UART TX pin driver.

---
 rtl/temp_sched_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/temp_report_scheduler.sv | 82 ++++++++
 tb/tb_temp_report_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/temp_sched_pkg.sv
// temp_sched_pkg: shared states, ASCII frame constants and digit encoder for the temperature report scheduler
package temp_sched_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR_C = 3'd1;
  localparam logic [2:0] ST_HDR_N = 3'd2;
  localparam logic [2:0] ST_COLON = 3'd3;
  localparam logic [2:0] ST_DIGIT = 3'd4;
  localparam logic [2:0] ST_CR    = 3'd5;
  localparam logic [2:0] ST_LF    = 3'd6;
  localparam logic [7:0] CHAR_C     = 8'h43;
  localparam logic [7:0] CHAR_COLON = 8'h3A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_ERR   = 8'h3F;
  localparam int FRAME_BYTES = 15;
  localparam int DIGITS = 10;
  function automatic logic [7:0] digit_char(input logic [3:0] n);
    return (n > 4'd9) ? CHAR_ERR : CHAR_ZERO + {4'h0, n};
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter searching strictly after the last granted channel
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output logic [3:0]        grant_idx
);
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [3:0] last_grant_q, last_grant_d;
  logic [IW-1:0] k;
  logic found;
  always_comb begin
    grant = '0;
    grant_idx = '0;
    k = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      k = IW'((int'(last_grant_q) + i) % NUM_CH);
      if (!found && req[k]) begin
        found = 1'b1;
        grant[k] = 1'b1;
        grant_idx = 4'(k);
      end
    end
    last_grant_d = (en && found) ? grant_idx : last_grant_q;
  end
  always_ff @(posedge clk) last_grant_q <= reset ? 4'(NUM_CH - 1) : last_grant_d;
endmodule

// File: rtl/temp_report_scheduler.sv
// temp_report_scheduler: shares one UART byte stream among channels, sending "C<n>:<10 digits>\r\n" frames
module temp_report_scheduler #(
  parameter int NUM_CH = 4,
  parameter int DIGITS = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_enable,
  input  logic [NUM_CH-1:0]          req_valid,
  input  logic [NUM_CH*DIGITS*4-1:0] req_bcd,
  output logic [NUM_CH-1:0]          req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic [3:0]                 active_ch,
  output logic                       frame_done,
  output logic                       bcd_err
);
  import temp_sched_pkg::*;
  logic [2:0] state_q, state_d;
  logic [3:0] digit_q, digit_d;
  logic [3:0] active_ch_q, active_ch_d;
  logic [DIGITS*4-1:0] result_q, result_d, picked;
  logic [NUM_CH-1:0] cand, grant;
  logic [3:0] grant_idx, nib;
  logic idle;
  assign idle = state_q == ST_IDLE;
  assign cand = req_valid & ch_enable;
  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk(clk), .reset(reset), .req(cand), .en(idle),
    .grant(grant), .grant_idx(grant_idx)
  );
  always_comb begin
    picked = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (grant[c]) picked = req_bcd[c*DIGITS*4 +: DIGITS*4];
  end
  assign nib = result_q[{digit_q, 2'b00} +: 4];
  // header and trailer states are numbered consecutively, so they simply step forward
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    result_d = result_q;
    active_ch_d = active_ch_q;
    case (state_q)
      ST_IDLE: if (|cand) begin
        state_d = ST_HDR_C;
        result_d = picked;
        active_ch_d = grant_idx;
      end
      ST_COLON: if (tx_ready) begin
        state_d = ST_DIGIT;
        digit_d = 4'(DIGITS - 1);
      end
      ST_DIGIT: if (tx_ready) begin
        state_d = (digit_q == 4'd0) ? ST_CR : ST_DIGIT;
        digit_d = digit_q - 4'd1;
      end
      ST_LF: if (tx_ready) state_d = ST_IDLE;
      default: if (tx_ready) state_d = state_q + 3'd1;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= reset ? ST_IDLE : state_d;
    digit_q <= reset ? 4'd0 : digit_d;
    active_ch_q <= reset ? 4'd0 : active_ch_d;
    result_q <= reset ? '0 : result_d;
  end
  assign req_ready = idle ? grant : '0;
  assign tx_valid = !idle;
  assign busy = !idle;
  assign active_ch = active_ch_q;
  assign frame_done = (state_q == ST_LF) && tx_ready;
  assign bcd_err = (state_q == ST_DIGIT) && tx_ready && (nib > 4'd9);
  assign tx_data = (state_q == ST_HDR_C) ? CHAR_C :
                   (state_q == ST_HDR_N) ? CHAR_ZERO + {4'h0, active_ch_q} :
                   (state_q == ST_COLON) ? CHAR_COLON :
                   (state_q == ST_DIGIT) ? digit_char(nib) :
                   (state_q == ST_CR)    ? CHAR_CR :
                   (state_q == ST_LF)    ? CHAR_LF : 8'h00;
endmodule

// File: tb/tb_temp_report_scheduler.sv
// tb_temp_report_scheduler: directed checks of framing, round-robin order, backpressure, masking and reset
module tb_temp_report_scheduler;
  import temp_sched_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] ch_enable = 4'hF;
  logic [3:0] req_valid = 4'h0;
  logic [159:0] req_bcd = '0;
  logic [3:0] req_ready;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready = 1'b0;
  logic busy;
  logic [3:0] active_ch;
  logic frame_done;
  logic bcd_err;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dones = 0;
  int errs = 0;
  logic [7:0] bytes[$];
  int g_ch[$];
  int g_cyc[$];
  logic hold_q = 1'b0;
  logic [7:0] hold_data = 8'h00;

  temp_report_scheduler #(.NUM_CH(4), .DIGITS(10)) dut (
    .clk(clk), .reset(reset), .ch_enable(ch_enable), .req_valid(req_valid),
    .req_bcd(req_bcd), .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .active_ch(active_ch),
    .frame_done(frame_done), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_valid && tx_ready) bytes.push_back(tx_data);
      if (frame_done) dones++;
      if (bcd_err) errs++;
      if (hold_q) begin
        check("hold_valid", 64'(tx_valid), 64'd1);
        check("hold_data", 64'(tx_data), 64'(hold_data));
      end
      if (busy) check("rdy_busy", 64'(req_ready), 64'd0);
      if (req_ready != 4'h0) begin
        check("rdy_onehot", 64'($countones(req_ready)), 64'd1);
        check("rdy_legal", 64'(req_ready & ~(req_valid & ch_enable)), 64'd0);
        for (int k = 0; k < 4; k++)
          if (req_ready[k]) begin
            g_ch.push_back(k);
            g_cyc.push_back(cyc);
          end
      end
    end
    hold_q = !reset && tx_valid && !tx_ready;
    hold_data = tx_data;
  end

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 4'h0;
    tx_ready = 1'b0;
    ch_enable = 4'hF;
    tick();
    tick();
    bytes.delete();
    g_ch.delete();
    g_cyc.delete();
    dones = 0;
    errs = 0;
    reset = 1'b0;
  endtask

  task automatic send_one(input int ch, input logic [39:0] bcd, input bit bp);
    logic [7:0] exp_b[15];
    logic [3:0] nb;
    int n;
    int exp_err;
    exp_err = 0;
    exp_b[0] = 8'h43;
    exp_b[1] = 8'h30 + 8'(ch);
    exp_b[2] = 8'h3A;
    for (int i = 0; i < 10; i++) begin
      nb = bcd[(9-i)*4 +: 4];
      exp_b[3+i] = (nb > 4'd9) ? 8'h3F : 8'h30 + {4'h0, nb};
      if (nb > 4'd9) exp_err++;
    end
    exp_b[13] = 8'h0D;
    exp_b[14] = 8'h0A;
    bytes.delete();
    dones = 0;
    errs = 0;
    req_bcd[ch*40 +: 40] = bcd;
    req_valid = 4'(1 << ch);
    tx_ready = 1'b1;
    #1;
    check("grant", 64'(req_ready), 64'(4'(1 << ch)));
    tick();
    req_valid = 4'h0;
    check("g1_busy", 64'(busy), 64'd1);
    check("g1_valid", 64'(tx_valid), 64'd1);
    check("g1_data", 64'(tx_data), 64'h43);
    check("g1_ch", 64'(active_ch), 64'(ch));
    n = 1;
    while (n < 200) begin
      tx_ready = bp ? (n % 3 == 0) : 1'b1;
      #1;
      if (frame_done) break;
      tick();
      n++;
    end
    if (!bp) check("done_lat", 64'(n), 64'd15);
    tick();
    check("idle_after", 64'(busy), 64'd0);
    check("dones", 64'(dones), 64'd1);
    check("nbytes", 64'(bytes.size()), 64'(FRAME_BYTES));
    for (int i = 0; i < 15 && i < bytes.size(); i++)
      check($sformatf("byte%0d", i), 64'(bytes[i]), 64'(exp_b[i]));
    check("bcd_errs", 64'(errs), 64'(exp_err));
  endtask

  initial begin
    int n;
    reset = 1'b1;
    tick();
    tick();
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(tx_valid), 64'd0);
    check("rst_data", 64'(tx_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ch", 64'(active_ch), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_err", 64'(bcd_err), 64'd0);
    do_reset();
    send_one(2, 40'h00_0000_1234, 1'b0);

    do_reset();
    req_valid = 4'hF;
    tx_ready = 1'b1;
    n = 0;
    while (g_ch.size() < 5 && n < 150) begin
      tick();
      n++;
    end
    check("rr_count", 64'(g_ch.size() >= 5), 64'd1);
    for (int i = 0; i < 5 && i < g_ch.size(); i++)
      check($sformatf("rr_order%0d", i), 64'(g_ch[i]), 64'(i % 4));
    for (int i = 1; i < 5 && i < g_cyc.size(); i++)
      check($sformatf("rr_space%0d", i), 64'(g_cyc[i] - g_cyc[i-1]), 64'd16);

    do_reset();
    send_one(1, 40'h98_7654_3210, 1'b1);

    do_reset();
    ch_enable = 4'b1011;
    req_valid = 4'hF;
    tx_ready = 1'b1;
    n = 0;
    while (g_ch.size() < 4 && n < 120) begin
      tick();
      n++;
    end
    check("mask_count", 64'(g_ch.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < g_ch.size(); i++)
      check($sformatf("mask_order%0d", i), 64'(g_ch[i]), (i == 2) ? 64'd3 : ((i == 3) ? 64'd0 : 64'(i)));
    do_reset();
    send_one(0, 40'h00_0000_000A, 1'b0);

    do_reset();
    req_bcd[3*40 +: 40] = 40'h11_1111_1111;
    req_valid = 4'b1000;
    tx_ready = 1'b1;
    #1;
    check("mid_grant", 64'(req_ready), 64'b1000);
    tick();
    req_valid = 4'h0;
    n = 0;
    while (bytes.size() < 5 && n < 30) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tx_ready = 1'b0;
    tick();
    check("mid_valid", 64'(tx_valid), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tx_ready = 1'b1;
    tick();
    check("mid_bytes", 64'(bytes.size()), 64'd5);
    check("mid_dones", 64'(dones), 64'd0);
    req_bcd[39:0] = 40'h00_0000_0042;
    req_valid = 4'b1001;
    #1;
    check("post_grant", 64'(req_ready), 64'b0001);
    tick();
    req_valid = 4'h0;
    check("post_data", 64'(tx_data), 64'h43);
    check("post_ch", 64'(active_ch), 64'd0);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check("post_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
